parallel_in_serial_out_piso_param: RTL
======================================

PARALLEL_IN_SERIAL_OUT_PISO_PARAM -- requirements
Module: parallel_in_serial_out_piso_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the parallel word width in bits; legal range 2..64.
REQ-002 SHALL have parameter LSB_FIRST, default 0; 0 = MSB shifted out first, 1 = LSB shifted out first.
REQ-003 SHALL have port Clk_In, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_In, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Load_Valid_In, input, 1, parallel word offered.
REQ-006 SHALL have port Load_Ready_Out, output, 1, block able to accept a word this cycle.
REQ-007 SHALL have port Parallel_Data_In, input, WIDTH, word to serialise, sampled only on an accepted load.
REQ-008 SHALL have port Shift_Enable_In, input, 1, bit-rate enable; one bit is consumed per cycle it is high.
REQ-009 SHALL have port Serial_Data_Out, output, 1, current serial bit.
REQ-010 SHALL have port Serial_Valid_Out, output, 1, Serial_Data_Out carries a frame bit.
REQ-011 SHALL have port Busy_Out, output, 1, high while in SHIFT.
REQ-012 SHALL have port Done_Out, output, 1, one-cycle pulse after the last bit of a frame is consumed.
REQ-013 SHALL have port PISO_Shift_Register, output, WIDTH, live shift-register contents for debug.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SHIFT, plus a bit counter of width $clog2(WIDTH+1).
REQ-015 A load SHALL be accepted on a rising edge where Load_Valid_In and Load_Ready_Out are both high.
REQ-016 An accepted load SHALL copy Parallel_Data_In into the shift register, set the counter to WIDTH, and enter SHIFT.
REQ-017 Load_Ready_Out SHALL be high in IDLE, or in SHIFT when counter == 1 and Shift_Enable_In is high; it SHALL be low otherwise.
REQ-018 Serial_Data_Out SHALL be combinational from the register: bit WIDTH-1 when LSB_FIRST=0, bit 0 when LSB_FIRST=1, forced 0 in IDLE.
REQ-019 Serial_Valid_Out and Busy_Out SHALL equal (state == SHIFT).
REQ-020 Latency: the first bit SHALL be valid in the cycle immediately after the accepting edge.
REQ-021 In SHIFT, each bit SHALL hold until an edge with Shift_Enable_In high.
REQ-022 On that edge the register SHALL shift toward the output end, fill with 0, and decrement the counter.
REQ-023 In SHIFT with Shift_Enable_In low, the register and counter SHALL hold.
REQ-024 On an edge with counter == 1 and Shift_Enable_In high, the frame SHALL complete.
REQ-025 At frame completion, Done_Out SHALL be high for exactly the following cycle.
REQ-026 At frame completion with no accepted load, the FSM SHALL enter IDLE and the register SHALL clear to 0.
REQ-027 Back-to-back: at frame completion with Load_Valid_In high, the new word SHALL load, the FSM SHALL stay in SHIFT, and there SHALL be no idle gap.
REQ-028 In the back-to-back case, Done_Out SHALL still pulse for the finished frame.
REQ-029 Load_Valid_In while Load_Ready_Out is low SHALL be ignored, with no state change.
REQ-030 Shift_Enable_In in IDLE SHALL be ignored.

Reset
REQ-031 Reset_In high SHALL immediately, without waiting for a clock edge, force IDLE, counter 0, and PISO_Shift_Register 0.
REQ-032 During reset, Serial_Data_Out, Serial_Valid_Out, Busy_Out and Done_Out SHALL be 0, and Load_Ready_Out SHALL be 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame, with no Done_Out pulse; after release, the next load SHALL start a fresh frame.

Verification
REQ-034 WIDTH=8, LSB_FIRST=0, load 0xD2, Shift_Enable_In held 1 -> Serial_Data_Out 1,1,0,1,0,0,1,0 over 8 cycles; Done_Out pulses in cycle 9; then IDLE.
REQ-035 Same setup with LSB_FIRST=1 -> Serial_Data_Out 0,1,0,0,1,0,1,1; Done_Out pulses once.
REQ-036 Load 0xD2, Shift_Enable_In high every third cycle -> each bit held 3 cycles; Busy_Out high for 24 cycles; same bit order as REQ-034.
REQ-037 Load 0xD2, Load_Valid_In held with 0x0F ready at the last bit -> Serial_Valid_Out never drops; 0x0F bits 0,0,0,0,1,1,1,1 follow immediately; two Done_Out pulses.
REQ-038 Assert Reset_In for 1 ns after 4 bits of 0xD2 -> outputs clear without a clock edge; no Done_Out; a following load of 0x80 shifts 1 then seven 0s.
REQ-039 Load_Valid_In pulsed with 0xFF mid-frame of 0xD2 -> ignored; the 0xD2 bit sequence is unchanged.

Source files
------------

// File: rtl/parallel_in_serial_out_piso_param.sv
// Parameterised parallel-in serial-out shifter with valid/ready load,
// bit-rate enable, back-to-back frames and a frame-done pulse.
module parallel_in_serial_out_piso_param #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Load_Valid_In,
  output logic             Load_Ready_Out,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  input  logic             Shift_Enable_In,
  output logic             Serial_Data_Out,
  output logic             Serial_Valid_Out,
  output logic             Busy_Out,
  output logic             Done_Out,
  output logic [WIDTH-1:0] PISO_Shift_Register
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             done;
  logic             last;
  logic             accept;

  // The final bit being consumed frees the register for a same-edge reload
  assign last   = (state == SHIFT) && (cnt == CW'(1)) && Shift_Enable_In;
  assign accept = Load_Valid_In && Load_Ready_Out;

  assign Load_Ready_Out = (state == IDLE) || last;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign sreg_next       = {1'b0, sreg[WIDTH-1:1]};
      assign Serial_Data_Out = (state == SHIFT) && sreg[0];
    end else begin : g_msb
      assign sreg_next       = {sreg[WIDTH-2:0], 1'b0};
      assign Serial_Data_Out = (state == SHIFT) && sreg[WIDTH-1];
    end
  endgenerate

  assign Serial_Valid_Out    = (state == SHIFT);
  assign Busy_Out            = (state == SHIFT);
  assign Done_Out            = done;
  assign PISO_Shift_Register = sreg;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        state <= SHIFT;
        cnt   <= CW'(WIDTH);
        sreg  <= Parallel_Data_In;
      end else if (last) begin
        state <= IDLE;
        cnt   <= '0;
        sreg  <= '0;
      end else if ((state == SHIFT) && Shift_Enable_In) begin
        cnt  <= cnt - CW'(1);
        sreg <= sreg_next;
      end
    end
  end

endmodule
